// File: rtl/significand_aligner.sv
// Alignment stage of the FP add/sub datapath: picks the smaller-exponent operand and
// right-shifts its significand by the exponent difference, one shift-amount bit per cycle.
module significand_aligner #(
    parameter int unsigned ExponentSize = 8,
    parameter int unsigned MantissaSize = 23
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic [ExponentSize-1:0]   Exponent1,
    input  logic [ExponentSize-1:0]   Exponent2,
    input  logic [MantissaSize:0]     Significand1,
    input  logic [MantissaSize:0]     Significand2,
    input  logic [ExponentSize-1:0]   Difference,
    input  logic                      Sign,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic [MantissaSize:0]     LargeSignificand,
    output logic [MantissaSize+3:0]   AlignedSignificand,
    output logic [ExponentSize-1:0]   ResultExponent,
    output logic                      Swapped
);

    localparam int unsigned S  = MantissaSize + 1;
    localparam int unsigned W  = S + 3;
    localparam int unsigned KW = (ExponentSize > 1) ? $clog2(ExponentSize) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]              state_q, state_d;
    logic                    out_valid_q, out_valid_d;
    logic                    in_ready_q, in_ready_d;
    logic                    accept;
    logic [KW-1:0]           k_q;
    logic [ExponentSize-1:0] shift_q;
    logic [W-1:0]            work_q, work_shift;
    logic [S-1:0]            large_q;
    logic [ExponentSize-1:0] exp_q;
    logic                    swapped_q;
    logic [31:0]             shift_amt;
    logic [W-2:0]            body, mask;

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Next state; OutValid rises one cycle after DONE is entered and drops on handoff
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (InValid) begin
                    accept  = 1'b1;
                    state_d = (Difference == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (k_q == KW'(ExponentSize - 1)) state_d = DONE;
            end
            DONE: begin
                if (out_valid_q && OutReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        out_valid_d = (state_q == DONE) && (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
    end

    // One stage of the logarithmic shifter: shift by 2^k, folding lost bits into sticky
    always_comb begin
        shift_amt  = 32'(1) << k_q;
        body       = work_q[W-1:1];
        mask       = ~({(W-1){1'b1}} << shift_amt);
        work_shift = {body >> shift_amt, work_q[0] | (|(body & mask))};
        if (shift_amt >= W) work_shift = {{(W-1){1'b0}}, |work_q};
    end

    // Operand capture and iterative shift
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            work_q    <= '0;
            large_q   <= '0;
            exp_q     <= '0;
            swapped_q <= 1'b0;
            shift_q   <= '0;
            k_q       <= '0;
        end else if (accept) begin
            work_q    <= Sign ? {Significand1, 3'b000} : {Significand2, 3'b000};
            large_q   <= Sign ? Significand2 : Significand1;
            exp_q     <= Sign ? Exponent2 : Exponent1;
            swapped_q <= Sign;
            shift_q   <= Difference;
            k_q       <= '0;
        end else if (state_q == SHIFT) begin
            if (shift_q[k_q]) work_q <= work_shift;
            k_q <= k_q + KW'(1);
        end
    end

    assign InReady            = in_ready_q;
    assign OutValid           = out_valid_q;
    assign LargeSignificand   = large_q;
    assign AlignedSignificand = work_q;
    assign ResultExponent     = exp_q;
    assign Swapped            = swapped_q;

endmodule

// File: tb/tb_significand_aligner.sv
// Randomized self-checking bench for significand_aligner against an arithmetic alignment model.
module tb_significand_aligner;

    logic        Clk;
    logic        Rst_n;
    logic        InValid;
    logic        InReady;
    logic [7:0]  Exponent1;
    logic [7:0]  Exponent2;
    logic [23:0] Significand1;
    logic [23:0] Significand2;
    logic [7:0]  Difference;
    logic        Sign;
    logic        OutValid;
    logic        OutReady;
    logic [23:0] LargeSignificand;
    logic [26:0] AlignedSignificand;
    logic [7:0]  ResultExponent;
    logic        Swapped;

    int total = 0;
    int bad   = 0;

    significand_aligner #(.ExponentSize(8), .MantissaSize(23)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .InValid(InValid), .InReady(InReady),
        .Exponent1(Exponent1), .Exponent2(Exponent2),
        .Significand1(Significand1), .Significand2(Significand2),
        .Difference(Difference), .Sign(Sign),
        .OutValid(OutValid), .OutReady(OutReady),
        .LargeSignificand(LargeSignificand), .AlignedSignificand(AlignedSignificand),
        .ResultExponent(ResultExponent), .Swapped(Swapped)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Exact right shift of {sig,G=0,R=0} by d, with every lost bit ORed into sticky
    function automatic logic [26:0] ref_align(input logic [23:0] sig, input int unsigned d);
        logic [63:0] body0, shifted;
        logic        lost;
        body0 = {38'd0, sig, 2'b00};
        if (d >= 64) begin
            shifted = 64'd0;
            lost    = (body0 != 64'd0);
        end else begin
            shifted = body0 >> d;
            lost    = ((body0 & ((64'd1 << d) - 64'd1)) != 64'd0);
        end
        return {shifted[25:0], lost};
    endfunction

    task automatic scramble();
        Exponent1    = 8'($urandom);
        Exponent2    = 8'($urandom);
        Significand1 = 24'($urandom);
        Significand2 = 24'($urandom);
        Difference   = 8'($urandom);
        Sign         = 1'($urandom);
    endtask

    task automatic do_op(input logic [7:0] e1, input logic [7:0] e2, input logic [7:0] d,
                         input logic [23:0] s1, input logic [23:0] s2, input logic sg,
                         input int bp);
        logic [26:0] exp_al;
        logic [23:0] exp_large;
        logic [7:0]  exp_e;
        int          cyc;
        exp_al    = ref_align(sg ? s1 : s2, int'(d));
        exp_large = sg ? s2 : s1;
        exp_e     = sg ? e2 : e1;
        check("in_ready_idle", 64'(InReady), 64'd1);
        Exponent1 = e1; Exponent2 = e2; Difference = d;
        Significand1 = s1; Significand2 = s2; Sign = sg;
        InValid = 1'b1;
        @(negedge Clk);
        InValid = 1'b0;
        scramble();
        cyc = 0;
        while (!OutValid && cyc < 40) begin
            @(negedge Clk);
            cyc++;
        end
        check("latency", 64'(cyc), (d == 8'd0) ? 64'd1 : 64'd9);
        check("in_ready_busy", 64'(InReady), 64'd0);
        check("aligned", 64'(AlignedSignificand), 64'(exp_al));
        check("large", 64'(LargeSignificand), 64'(exp_large));
        check("exponent", 64'(ResultExponent), 64'(exp_e));
        check("swapped", 64'(Swapped), 64'(sg));
        for (int i = 0; i < bp; i++) begin
            InValid = 1'b1;
            scramble();
            @(negedge Clk);
            check("hold_valid", 64'(OutValid), 64'd1);
            check("hold_in_ready", 64'(InReady), 64'd0);
            check("hold_aligned", 64'(AlignedSignificand), 64'(exp_al));
            check("hold_exponent", 64'(ResultExponent), 64'(exp_e));
        end
        InValid  = 1'b1;
        OutReady = 1'b1;
        scramble();
        @(negedge Clk);
        OutReady = 1'b0;
        InValid  = 1'b0;
        check("handoff_valid", 64'(OutValid), 64'd0);
        check("handoff_in_ready", 64'(InReady), 64'd1);
        check("handoff_no_capture_exp", 64'(ResultExponent), 64'(exp_e));
        check("handoff_no_capture_large", 64'(LargeSignificand), 64'(exp_large));
    endtask

    initial begin
        logic       seen;
        logic [7:0] d;
        Rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b0;
        Exponent1 = '0; Exponent2 = '0; Significand1 = '0; Significand2 = '0;
        Difference = '0; Sign = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_out_valid", 64'(OutValid), 64'd0);
        check("rst_in_ready", 64'(InReady), 64'd1);
        check("rst_aligned", 64'(AlignedSignificand), 64'd0);
        check("rst_large", 64'(LargeSignificand), 64'd0);
        check("rst_exponent", 64'(ResultExponent), 64'd0);
        check("rst_swapped", 64'(Swapped), 64'd0);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Directed cases with hand-derived results
        do_op(8'h80, 8'h80, 8'd0, 24'h800000, 24'hC00000, 1'b0, 0);
        check("zero_diff_value", 64'(AlignedSignificand), 64'h6000000);
        do_op(8'h81, 8'h80, 8'd1, 24'h900000, 24'h800001, 1'b0, 1);
        check("shift1_value", 64'(AlignedSignificand), 64'h2000004);
        do_op(8'h7D, 8'h80, 8'd3, 24'h80000F, 24'hA00000, 1'b1, 2);
        check("shift3_value", 64'(AlignedSignificand), 64'h080000F);
        do_op(8'h9E, 8'h80, 8'd30, 24'hFFFFFF, 24'h800000, 1'b0, 0);
        check("shift30_value", 64'(AlignedSignificand), 64'h0000001);
        do_op(8'hFF, 8'h00, 8'hFF, 24'hFFFFFF, 24'h800000, 1'b0, 0);
        check("shiftff_value", 64'(AlignedSignificand), 64'h0000001);
        do_op(8'hFF, 8'h00, 8'hFF, 24'hFFFFFF, 24'h000000, 1'b0, 0);
        check("shiftff_zero_value", 64'(AlignedSignificand), 64'h0000000);
        do_op(8'h90, 8'h80, 8'd16, 24'h800000, 24'hFFFFFF, 1'b0, 5);

        // Reset in the middle of a shift
        Exponent1 = 8'h85; Exponent2 = 8'h80; Difference = 8'd5;
        Significand1 = 24'hC00000; Significand2 = 24'h812345; Sign = 1'b0;
        InValid = 1'b1;
        @(negedge Clk);
        InValid = 1'b0;
        repeat (4) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(OutValid), 64'd0);
        check("midrst_aligned", 64'(AlignedSignificand), 64'd0);
        check("midrst_large", 64'(LargeSignificand), 64'd0);
        check("midrst_exponent", 64'(ResultExponent), 64'd0);
        check("midrst_in_ready", 64'(InReady), 64'd1);
        @(negedge Clk);
        Rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(negedge Clk);
            if (OutValid) seen = 1'b1;
        end
        check("midrst_no_valid", 64'(seen), 64'd0);

        // Randomized operand sets
        for (int n = 0; n < 40; n++) begin
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 30));
            do_op(8'($urandom), 8'($urandom), d,
                  ($urandom_range(0, 7) == 0) ? 24'd0 : {1'b1, 23'($urandom)},
                  ($urandom_range(0, 7) == 0) ? 24'd0 : {1'b1, 23'($urandom)},
                  1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/significand_aligner.md
Name: significand_aligner

Overview:
- Alignment stage directly downstream of the exponent-difference block in the FP add/sub datapath.
- Consumes the exponent pair, their difference and the difference sign. Selects the operand with the smaller exponent and right-shifts its significand by the difference, producing guard, round and sticky bits.
- Iterative shifter: one shift-amount bit per cycle, with a valid/ready handshake on input and output.
- Feeds the significand adder/subtractor stage.

Parameters:
- ExponentSize, 8: exponent width; equals the number of SHIFT cycles.
- MantissaSize, 23: fraction width. Significand width S = MantissaSize+1 (hidden bit included). Working width W = S+3.

Ports:
- Clk  input  1  rising-edge clock
- Rst_n  input  1  asynchronous active-low reset
- InValid  input  1  input operands valid
- InReady  output  1  block can accept; high only in IDLE
- Exponent1  input  ExponentSize  exponent of operand 1
- Exponent2  input  ExponentSize  exponent of operand 2
- Significand1  input  S  significand of operand 1, hidden bit at MSB
- Significand2  input  S  significand of operand 2
- Difference  input  ExponentSize  |Exponent1-Exponent2| from the upstream stage
- Sign  input  1  1 when Exponent2 > Exponent1
- OutValid  output  1  result valid
- OutReady  input  1  consumer accepts the result
- LargeSignificand  output  S  significand of the larger-exponent operand
- AlignedSignificand  output  W  shifted significand; bit order {S bits, G, R, Sticky}
- ResultExponent  output  ExponentSize  larger exponent
- Swapped  output  1  registered Sign

Behaviour:
- Reset (async, Rst_n=0):
  - State goes to IDLE.
  - All registered outputs are 0: OutValid, LargeSignificand, AlignedSignificand, ResultExponent, Swapped.
  - InReady=1 once in IDLE.
  - Reset asserted in any state aborts the operation; no OutValid is produced for that operand set.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - InReady=1.
  - On InValid=1 at a clock edge, capture the operands.
    - Sign=1: WorkReg={Significand1,3'b000}, LargeSignificand=Significand2, ResultExponent=Exponent2.
    - Sign=0: WorkReg={Significand2,3'b000}, LargeSignificand=Significand1, ResultExponent=Exponent1.
  - Also capture Difference into ShiftReg and Sign into Swapped; clear stage counter k.
  - Next state is DONE if Difference==0, else SHIFT.
  - InValid=0: remain in IDLE, no captures.
- SHIFT:
  - One cycle per k = 0..ExponentSize-1, always exactly ExponentSize cycles.
  - If ShiftReg[k]=0, WorkReg is unchanged.
  - If ShiftReg[k]=1 and 2^k < W:
    - WorkReg[W-1:1] becomes WorkReg[W-1:1] >> 2^k.
    - Sticky becomes old Sticky OR all bits shifted out of WorkReg[W-1:1].
  - If ShiftReg[k]=1 and 2^k >= W: WorkReg[W-1:1]=0 and Sticky = OR of the whole old WorkReg.
  - After k=ExponentSize-1, go to DONE.
  - Net effect: any Difference >= W yields AlignedSignificand = {0…0, Sticky}, with Sticky=1 iff the shifted significand was nonzero.
- DONE:
  - OutValid=1; AlignedSignificand=WorkReg.
  - All outputs hold stable until OutReady=1.
  - On OutReady=1, OutValid falls at the next edge and the state goes to IDLE.
  - No input is accepted in DONE, even in the handoff cycle.
- Latency, counted from the accepting edge:
  - Difference==0: OutValid high 1 cycle later.
  - Otherwise: OutValid high ExponentSize+1 cycles later.
  - Minimum initiation interval is latency+1.
- Ignored inputs:
  - InValid while not in IDLE is ignored; the upstream stage must hold it.
  - Input changes during SHIFT/DONE have no effect.
- Difference is trusted as given; it is not recomputed from the exponents.

Test Plan:
- Zero difference: Exponent1=Exponent2=0x80, Difference=0, Sign=0, Significand1=0x800000, Significand2=0xC00000 -> OutValid 1 cycle after accept; AlignedSignificand=0x6000000, LargeSignificand=0x800000, ResultExponent=0x80, Swapped=0.
- Shift by 1, guard set: Exponent1=0x81, Exponent2=0x80, Difference=1, Sign=0, Significand2=0x800001 -> after 9 cycles AlignedSignificand=0x2000004 (G=1, R=0, S=0).
- Swap and shift by 3: Exponent1=0x7D, Exponent2=0x80, Difference=3, Sign=1, Significand1=0x80000F, Significand2=0xA00000 -> AlignedSignificand=0x080000F, LargeSignificand=0xA00000, ResultExponent=0x80, Swapped=1.
- Oversized shift: Difference=30, then Difference=0xFF, Sign=0, Significand2=0x800000 -> AlignedSignificand=0x0000001 in both runs. With Significand2=0 -> AlignedSignificand=0.
- Backpressure: hold OutReady=0 for 5 cycles in DONE while pulsing InValid -> OutValid and all outputs stable, InReady=0, new operands not captured. Raise OutReady -> OutValid=0 and InReady=1 next cycle.
- Reset mid-operation: assert Rst_n=0 at SHIFT cycle k=4 -> outputs 0 immediately (async). After release: IDLE, InReady=1, no OutValid until a new accept.
